expand_s_ctrl: RTL and testbench

Sequencer for the ML-DSA ExpandS sampling stage. For each of the L+K secret polynomials it absorbs rho' || nonce into the shared SHAKE256 core and hands each 1088-bit squeezed block to the ExpandS sampler. It requests a further squeeze whenever the sampler exhausts a block, and advances to the next polynomial when the sampler reports 256 coefficients written. The block sits between the key-generation top FSM, the SHAKE256 core and the ExpandS sampler.

---
 rtl/expand_s_ctrl.sv | 161 ++++++++++++++++
 tb/tb_expand_s_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/expand_s_ctrl.sv
// ExpandS sequencer: absorbs rho' || nonce per secret polynomial into SHAKE256 and
// paces squeezed blocks into the ExpandS sampler until all L+K polynomials are written.
module expand_s_ctrl #(
   parameter int unsigned L          = 4,
   parameter int unsigned K          = 4,
   parameter int unsigned MAX_BLOCKS = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [511:0] rho_prime,
   input  logic         shake_ready,
   output logic         shake_start,
   output logic [527:0] shake_msg,
   input  logic         shake_block_valid,
   output logic         shake_squeeze,
   output logic         sample_in_ready,
   input  logic         sample_counter_full,
   input  logic         sample_next_element,
   output logic [3:0]   poly_idx,
   output logic         s_sel,
   output logic [2:0]   local_idx,
   output logic         busy,
   output logic         done,
   output logic         err
);

   localparam int unsigned CntW    = $clog2(MAX_BLOCKS + 1);
   localparam logic [3:0]  LastIdx = 4'(L + K - 1);
   localparam logic [3:0]  LIdx    = 4'(L);

   typedef enum logic [2:0] {
      StIdle, StAbsorb, StWaitBlk, StSample, StNextPoly, StFinish
   } state_e;

   state_e            state_q, state_d;
   logic [511:0]      rho_q, rho_d;
   logic [3:0]        poly_idx_q, poly_idx_d;
   logic [CntW-1:0]   block_cnt_q, block_cnt_d;
   logic              err_q, err_d;
   logic              shake_start_q, shake_start_d;
   logic              shake_squeeze_q, shake_squeeze_d;
   logic              sample_in_ready_q, sample_in_ready_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              s_sel_q, s_sel_d;
   logic [2:0]        local_idx_q, local_idx_d;

   always_comb begin
      state_d           = state_q;
      rho_d             = rho_q;
      poly_idx_d        = poly_idx_q;
      block_cnt_d       = block_cnt_q;
      err_d             = err_q;
      shake_start_d     = 1'b0;
      shake_squeeze_d   = 1'b0;
      sample_in_ready_d = 1'b0;
      done_d            = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               rho_d       = rho_prime;
               poly_idx_d  = 4'd0;
               block_cnt_d = '0;
               err_d       = 1'b0;
               state_d     = StAbsorb;
            end
         end
         StAbsorb: begin
            if (shake_ready) begin
               shake_start_d = 1'b1;
               state_d       = StWaitBlk;
            end
         end
         StWaitBlk: begin
            if (shake_block_valid) begin
               sample_in_ready_d = 1'b1;
               block_cnt_d       = block_cnt_q + CntW'(1);
               state_d           = StSample;
            end
         end
         StSample: begin
            // A finished polynomial never triggers a squeeze, even on a full block.
            if (sample_next_element) begin
               state_d = StNextPoly;
            end else if (sample_counter_full) begin
               if (block_cnt_q == CntW'(MAX_BLOCKS)) begin
                  err_d   = 1'b1;
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  shake_squeeze_d = 1'b1;
                  state_d         = StWaitBlk;
               end
            end
         end
         StNextPoly: begin
            block_cnt_d = '0;
            if (poly_idx_q == LastIdx) begin
               state_d = StFinish;
            end else begin
               poly_idx_d = poly_idx_q + 4'd1;
               state_d    = StAbsorb;
            end
         end
         StFinish: begin
            done_d  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      busy_d      = (state_d != StIdle);
      s_sel_d     = (poly_idx_d >= LIdx);
      local_idx_d = s_sel_d ? 3'(poly_idx_d - LIdx) : poly_idx_d[2:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q           <= StIdle;
         rho_q             <= '0;
         poly_idx_q        <= 4'd0;
         block_cnt_q       <= '0;
         err_q             <= 1'b0;
         shake_start_q     <= 1'b0;
         shake_squeeze_q   <= 1'b0;
         sample_in_ready_q <= 1'b0;
         done_q            <= 1'b0;
         busy_q            <= 1'b0;
         s_sel_q           <= 1'b0;
         local_idx_q       <= 3'd0;
      end else begin
         state_q           <= state_d;
         rho_q             <= rho_d;
         poly_idx_q        <= poly_idx_d;
         block_cnt_q       <= block_cnt_d;
         err_q             <= err_d;
         shake_start_q     <= shake_start_d;
         shake_squeeze_q   <= shake_squeeze_d;
         sample_in_ready_q <= sample_in_ready_d;
         done_q            <= done_d;
         busy_q            <= busy_d;
         s_sel_q           <= s_sel_d;
         local_idx_q       <= local_idx_d;
      end
   end

   // Nonce is poly_idx zero-extended to 16 bits, least significant byte first.
   assign shake_msg       = {12'h000, poly_idx_q, rho_q};
   assign shake_start     = shake_start_q;
   assign shake_squeeze   = shake_squeeze_q;
   assign sample_in_ready = sample_in_ready_q;
   assign poly_idx        = poly_idx_q;
   assign s_sel           = s_sel_q;
   assign local_idx       = local_idx_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err             = err_q;

endmodule

// File: tb/tb_expand_s_ctrl.sv
// Directed bench for expand_s_ctrl: a vector table for the basic handshakes plus
// hand sequences for full runs, ABSORB stall, MAX_BLOCKS abort and mid-run reset.
module tb_expand_s_ctrl;

   localparam logic [511:0] RHO = {8{64'h0123_4567_89ab_cdef}};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, shake_ready = 1'b0, bv = 1'b0, cf = 1'b0, ne = 1'b0;
   logic [511:0] rho_prime = RHO;

   logic         ss, sq, ir, s_sel, busy, done, err;
   logic [527:0] msg;
   logic [3:0]   poly_idx;
   logic [2:0]   local_idx;

   logic         m2_ss, m2_sq, m2_ir, m2_s_sel, m2_busy, m2_done, m2_err;
   logic [527:0] m2_msg;
   logic [3:0]   m2_poly_idx;
   logic [2:0]   m2_local_idx;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   expand_s_ctrl dut (
      .clk(clk), .reset(rst_n), .start(start), .rho_prime(rho_prime),
      .shake_ready(shake_ready), .shake_start(ss), .shake_msg(msg),
      .shake_block_valid(bv), .shake_squeeze(sq), .sample_in_ready(ir),
      .sample_counter_full(cf), .sample_next_element(ne), .poly_idx(poly_idx),
      .s_sel(s_sel), .local_idx(local_idx), .busy(busy), .done(done), .err(err)
   );

   expand_s_ctrl #(.L(4), .K(4), .MAX_BLOCKS(2)) dut_m2 (
      .clk(clk), .reset(rst_n), .start(start), .rho_prime(rho_prime),
      .shake_ready(shake_ready), .shake_start(m2_ss), .shake_msg(m2_msg),
      .shake_block_valid(bv), .shake_squeeze(m2_sq), .sample_in_ready(m2_ir),
      .sample_counter_full(cf), .sample_next_element(ne), .poly_idx(m2_poly_idx),
      .s_sel(m2_s_sel), .local_idx(m2_local_idx), .busy(m2_busy), .done(m2_done),
      .err(m2_err)
   );

   typedef struct packed {
      logic [4:0] in;    // {start, shake_ready, block_valid, counter_full, next_element}
      logic [2:0] pls;   // {shake_start, shake_squeeze, sample_in_ready}
      logic [3:0] poly;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tbl [19];

   task automatic chk(input string name, input logic [527:0] act, input logic [527:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      start = 1'b0; shake_ready = 1'b0; bv = 1'b0; cf = 1'b0; ne = 1'b0;
   endtask

   task automatic do_reset();
      clr_in();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   function automatic logic [2:0] exp_local(input int p);
      return (p >= 4) ? 3'(p - 4) : 3'(p);
   endfunction

   // Drives a full run with a simple SHAKE/sampler model; poly 2 takes need2 blocks.
   // Returns early once a block is handed over for stop_poly.
   task automatic run_seq(input int need2, input int stop_poly, input string tag);
      int  nstart = 0;
      int  nsq2 = 0;
      int  blocks = 0;
      int  ndone = 0;
      bit  prev_bv = 1'b0;
      bit  stopped = 1'b0;
      clr_in();
      start = 1'b1;
      step();
      start = 1'b0;
      shake_ready = 1'b1;
      for (int cyc = 0; cyc < 2000 && ndone == 0 && !stopped; cyc++) begin
         step();
         if (prev_bv) chk({tag, " in_ready latency"}, 528'(ir), 528'(1));
         bv = 1'b0; cf = 1'b0; ne = 1'b0;
         if (ss) begin
            chk({tag, " msg"}, msg, {12'h000, 4'(nstart), RHO});
            chk({tag, " s_sel"}, 528'(s_sel), 528'(nstart >= 4));
            chk({tag, " local_idx"}, 528'(local_idx), 528'(exp_local(nstart)));
            nstart++;
            blocks = 0;
            bv = 1'b1;
         end
         if (sq) begin
            if (poly_idx == 4'd2) nsq2++;
            bv = 1'b1;
         end
         if (ir) begin
            blocks++;
            if (blocks < ((poly_idx == 4'd2) ? need2 : 1)) cf = 1'b1;
            else ne = 1'b1;
            if (int'(poly_idx) == stop_poly) stopped = 1'b1;
         end
         if (done) ndone++;
         prev_bv = bv;
      end
      if (stop_poly > 7) begin
         chk({tag, " done count"}, 528'(ndone), 528'(1));
         chk({tag, " shake_start count"}, 528'(nstart), 528'(8));
         chk({tag, " poly2 squeezes"}, 528'(nsq2), 528'(need2 - 1));
         chk({tag, " busy after done"}, 528'(busy), 528'(0));
         chk({tag, " err after done"}, 528'(err), 528'(0));
         chk({tag, " final poly_idx"}, 528'(poly_idx), 528'(7));
         clr_in();
         step();
         chk({tag, " done single pulse"}, 528'(done), 528'(0));
      end else begin
         chk({tag, " reached stop poly"}, 528'(stopped), 528'(1));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{5'b11000, 3'b000, 4'd0, 1'b1, 1'b0};
      tbl[1]  = '{5'b01000, 3'b100, 4'd0, 1'b1, 1'b0};
      tbl[2]  = '{5'b00000, 3'b000, 4'd0, 1'b1, 1'b0};
      tbl[3]  = '{5'b00100, 3'b001, 4'd0, 1'b1, 1'b0};
      tbl[4]  = '{5'b00010, 3'b010, 4'd0, 1'b1, 1'b0};
      tbl[5]  = '{5'b00100, 3'b001, 4'd0, 1'b1, 1'b0};
      tbl[6]  = '{5'b00010, 3'b010, 4'd0, 1'b1, 1'b0};
      tbl[7]  = '{5'b00100, 3'b001, 4'd0, 1'b1, 1'b0};
      tbl[8]  = '{5'b00000, 3'b000, 4'd0, 1'b1, 1'b0};
      tbl[9]  = '{5'b00001, 3'b000, 4'd0, 1'b1, 1'b0};
      tbl[10] = '{5'b00000, 3'b000, 4'd1, 1'b1, 1'b0};
      tbl[11] = '{5'b01000, 3'b100, 4'd1, 1'b1, 1'b0};
      tbl[12] = '{5'b00100, 3'b001, 4'd1, 1'b1, 1'b0};
      tbl[13] = '{5'b00011, 3'b000, 4'd1, 1'b1, 1'b0};
      tbl[14] = '{5'b00000, 3'b000, 4'd2, 1'b1, 1'b0};
      tbl[15] = '{5'b10000, 3'b000, 4'd2, 1'b1, 1'b0};
      tbl[16] = '{5'b01100, 3'b100, 4'd2, 1'b1, 1'b0};
      tbl[17] = '{5'b00010, 3'b000, 4'd2, 1'b1, 1'b0};
      tbl[18] = '{5'b00100, 3'b001, 4'd2, 1'b1, 1'b0};

      // Reset state
      clr_in();
      step();
      step();
      chk("reset busy", 528'(busy), 528'(0));
      chk("reset done", 528'(done), 528'(0));
      chk("reset err", 528'(err), 528'(0));
      chk("reset poly_idx", 528'(poly_idx), 528'(0));
      chk("reset msg", msg, 528'(0));
      chk("reset pulses", 528'({ss, sq, ir}), 528'(0));
      chk("reset s_sel/local", 528'({s_sel, local_idx}), 528'(0));
      rst_n = 1'b1;

      // Vector table
      for (int i = 0; i < 19; i++) begin
         {start, shake_ready, bv, cf, ne} = tbl[i].in;
         step();
         chk($sformatf("vec%0d pulses", i), 528'({ss, sq, ir}), 528'(tbl[i].pls));
         chk($sformatf("vec%0d poly_idx", i), 528'(poly_idx), 528'(tbl[i].poly));
         chk($sformatf("vec%0d s_sel", i), 528'(s_sel), 528'(tbl[i].poly >= 4'd4));
         chk($sformatf("vec%0d local_idx", i), 528'(local_idx),
             528'(exp_local(int'(tbl[i].poly))));
         chk($sformatf("vec%0d busy/done/err", i), 528'({busy, done, err}),
             528'({tbl[i].busy, tbl[i].done, 1'b0}));
         chk($sformatf("vec%0d msg", i), msg, {12'h000, tbl[i].poly, RHO});
      end

      // Full run, poly 2 needs three blocks
      do_reset();
      run_seq(3, 99, "full");

      // ABSORB stall with start pulsed while busy
      do_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         step();
         chk($sformatf("stall%0d shake_start", i), 528'(ss), 528'(0));
         chk($sformatf("stall%0d busy/poly", i), 528'({busy, poly_idx}), 528'({1'b1, 4'd0}));
      end
      start = 1'b0;
      shake_ready = 1'b1;
      step();
      chk("stall release shake_start", 528'(ss), 528'(1));
      shake_ready = 1'b0;
      step();
      chk("stall shake_start one cycle", 528'(ss), 528'(0));

      // MAX_BLOCKS=2 abort, err sticky until next start
      do_reset();
      start = 1'b1;
      step();
      start = 1'b0;
      shake_ready = 1'b1;
      step();
      chk("m2 shake_start", 528'(m2_ss), 528'(1));
      shake_ready = 1'b0;
      bv = 1'b1;
      step();
      chk("m2 in_ready 1", 528'(m2_ir), 528'(1));
      bv = 1'b0; cf = 1'b1;
      step();
      chk("m2 squeeze", 528'({m2_sq, m2_err, m2_done}), 528'(3'b100));
      cf = 1'b0; bv = 1'b1;
      step();
      chk("m2 in_ready 2", 528'(m2_ir), 528'(1));
      bv = 1'b0; cf = 1'b1;
      step();
      chk("m2 abort done/err/busy/sq", 528'({m2_done, m2_err, m2_busy, m2_sq}), 528'(4'b1100));
      cf = 1'b0;
      step();
      chk("m2 err sticky", 528'({m2_done, m2_err}), 528'(2'b01));
      start = 1'b1;
      step();
      start = 1'b0;
      chk("m2 start clears err", 528'({m2_err, m2_busy}), 528'(2'b01));

      // Reset mid poly 5, then restart from nonce 0
      do_reset();
      run_seq(1, 5, "pre-rst");
      clr_in();
      rst_n = 1'b0;
      #2;
      chk("async rst pulses", 528'({ss, sq, ir, done}), 528'(0));
      chk("async rst busy/err", 528'({busy, err}), 528'(0));
      chk("async rst poly/s_sel/local", 528'({poly_idx, s_sel, local_idx}), 528'(0));
      chk("async rst msg", msg, 528'(0));
      step();
      rst_n = 1'b1;
      step();
      chk("post rst no done", 528'({done, busy}), 528'(0));
      run_seq(1, 99, "restart");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
